// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory responder: read FSM states and the
// strobe-to-lane shift helper used by both the write path and alignment check.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // Bits [7:4] of the result are the lanes that spill past the word.
    function automatic logic [7:0] lane_shift(input logic [3:0] strb, input logic [1:0] off);
        return {4'b0000, strb} << off;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// DEPTH x 32 data array: one byte-wide array per lane, synchronous
// per-lane write and asynchronous read.
module dmem_sram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    lane_mem[waddr] <= wdata[gi*8 +: 8];
                end
            end

            assign rdata[gi*8 +: 8] = lane_mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: byte-lane writes plus a fixed-latency read FSM.
// Optional build macro DMEM_ALIGN_CHECK_EN enables misalignment reporting.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_en_in,
    input  logic        mem_write_en_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    input  logic [3:0]  mem_byte_num_in,
    output logic        mem_valid_out,
    output logic [31:0] mem_rdata_out,
    output logic        mem_busy_out,
    output logic        mem_err_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    dmem_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] cap_idx_q, cap_idx_d;
    logic [1:0]    cap_off_q, cap_off_d;
    logic          cap_mis_q, cap_mis_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          wr_err_q, wr_err_d;

    logic [AW-1:0] in_idx;
    logic [1:0]    in_off;
    logic [7:0]    strb_shifted;
    logic          in_mis;
    logic [3:0]    sram_we;
    logic [31:0]   sram_wdata;
    logic [AW-1:0] sram_raddr;
    logic [31:0]   sram_rdata;
    logic [1:0]    rd_off;
    logic          rd_mis;
    logic          load_resp;
    logic          unused_addr;

    assign in_idx       = mem_addr_in[AW+1:2];
    assign in_off       = mem_addr_in[1:0];
    assign strb_shifted = lane_shift(mem_byte_num_in, in_off);
    assign sram_wdata   = mem_wdata_in << {in_off, 3'b000};
    assign unused_addr  = ^mem_addr_in[31:AW+2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign in_mis   = |strb_shifted[7:4];
    assign sram_we  = (mem_write_en_in && !in_mis) ? strb_shifted[3:0] : 4'b0000;
    assign wr_err_d = mem_write_en_in && in_mis;
`else
    logic unused_spill;
    assign unused_spill = ^strb_shifted[7:4];
    assign in_mis   = 1'b0;
    assign sram_we  = mem_write_en_in ? strb_shifted[3:0] : 4'b0000;
    assign wr_err_d = 1'b0;
`endif

    // In IDLE the array is addressed from the live request (LATENCY=1 path);
    // afterwards only the captured address matters.
    assign sram_raddr = (state_q == DMEM_IDLE) ? in_idx : cap_idx_q;
    assign rd_off     = (state_q == DMEM_IDLE) ? in_off : cap_off_q;
    assign rd_mis     = (state_q == DMEM_IDLE) ? in_mis : cap_mis_q;

    dmem_sram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we),
        .waddr (in_idx),
        .wdata (sram_wdata),
        .raddr (sram_raddr),
        .rdata (sram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_idx_d = cap_idx_q;
        cap_off_d = cap_off_q;
        cap_mis_d = cap_mis_q;
        load_resp = 1'b0;

        case (state_q)
            DMEM_IDLE: begin
                if (mem_read_en_in) begin
                    cap_idx_d = in_idx;
                    cap_off_d = in_off;
                    cap_mis_d = in_mis;
                    cnt_d     = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d   = DMEM_RESP;
                        load_resp = 1'b1;
                    end else begin
                        state_d = DMEM_WAIT;
                    end
                end
            end
            DMEM_WAIT: begin
                // A dropped request is a pipeline flush and wins over completion.
                if (!mem_read_en_in) begin
                    state_d = DMEM_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= CW'(1)) begin
                    state_d   = DMEM_RESP;
                    cnt_d     = '0;
                    load_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DMEM_RESP: begin
                state_d = DMEM_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = DMEM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (load_resp) begin
            rdata_d = rd_mis ? 32'h0 : (sram_rdata >> {rd_off, 3'b000});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DMEM_IDLE;
            cnt_q     <= '0;
            cap_idx_q <= '0;
            cap_off_q <= '0;
            cap_mis_q <= 1'b0;
            rdata_q   <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_idx_q <= cap_idx_d;
            cap_off_q <= cap_off_d;
            cap_mis_q <= cap_mis_d;
            rdata_q   <= rdata_d;
            wr_err_q  <= wr_err_d;
        end
    end

    assign mem_valid_out = (state_q == DMEM_RESP);
    assign mem_busy_out  = (state_q != DMEM_IDLE);
    assign mem_rdata_out = rdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign mem_err_out = wr_err_q | (mem_valid_out & cap_mis_q);
`else
    logic unused_err;
    assign unused_err  = wr_err_q | cap_mis_q;
    assign mem_err_out = 1'b0;
`endif

endmodule
